reduce_stim_checker: RTL and testbench

- Self-checking driver for an AND/OR reduction unit: after `start`, applies every WIDTH-bit input vector to the unit under test.
- Samples the unit's reduction outputs, compares them against internally computed expected values, and counts mismatches.
- Sits on the opposite side of the reduction interface, driving the input vector and consuming `dut_and`/`dut_or`.
- Used in bring-up and regression harnesses.

---
 rtl/reduce_stim_checker.sv | 145 ++++++++++++++
 tb/tb_reduce_stim_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_stim_checker.sv
// Exhaustive stimulus driver and checker for an AND/OR reduction unit.
// Sweeps every WIDTH-bit vector, compares LAT-delayed responses and counts mismatches.
module reduce_stim_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_and,
  input  logic             dut_or,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_vec,
  output logic [1:0]       state_dbg
);

  // Request/response: start is a one-cycle request honoured only in IDLE;
  // done is a one-cycle completion pulse, and results hold until the next accepted start.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PW = (LAT > 0) ? LAT : 1;
  localparam logic [WIDTH-1:0] STIM_MAX   = '1;
  localparam logic [WIDTH-1:0] STIM_ONE   = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);
  localparam logic [1:0]       DRAIN_LOAD = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  state_t           state;
  logic [1:0]       drain_cnt;
  logic             cur_vld;
  logic             start_acc;
  logic [PW-1:0]    pipe_vld;
  logic [WIDTH-1:0] pipe_vec [PW];
  logic             tap_vld;
  logic [WIDTH-1:0] tap_vec;
  logic             mismatch;

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign cur_vld   = (state == DRIVE);
  assign start_acc = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stim      <= '0;
      done      <= 1'b0;
      drain_cnt <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= DRIVE;
            stim  <= '0;
          end
        end
        DRIVE: begin
          if (stim == STIM_MAX) begin
            if (LAT == 0) begin
              state <= IDLE;
              done  <= 1'b1;
              stim  <= '0;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            stim <= stim + STIM_ONE;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= IDLE;
            done  <= 1'b1;
            stim  <= '0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          stim  <= '0;
        end
      endcase
    end
  end

  // Expected-model pipeline: tags each driven vector so its response is
  // checked exactly LAT cycles later, including the final ones drained in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < PW; i++) pipe_vec[i] <= '0;
    end else begin
      pipe_vld[0] <= cur_vld;
      pipe_vec[0] <= stim;
      for (int i = 1; i < PW; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_vec[i] <= pipe_vec[i-1];
      end
    end
  end

  always_comb begin
    tap_vld = cur_vld;
    tap_vec = stim;
    if (LAT > 0) begin
      tap_vld = pipe_vld[PW-1];
      tap_vec = pipe_vec[PW-1];
    end
  end

  // One count per vector even if both reductions disagree.
  assign mismatch = (dut_and != (&tap_vec)) || (dut_or != (|tap_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (start_acc) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (tap_vld && mismatch) begin
      if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_vec   <= tap_vec;
      end
    end
  end

endmodule

// File: tb/tb_reduce_stim_checker.sv
// Bench for reduce_stim_checker: four instances (LAT/ERR_W variants) fed by small
// behavioural reduction models; sweep results are scoreboarded on each done pulse.
module tb_reduce_stim_checker;

  logic clk;
  logic rst_n;
  logic [3:0] start;
  logic [1:0] mode;

  logic [3:0] stim_v  [4];
  logic       and_m   [4];
  logic       or_m    [4];
  logic       busy_v  [4];
  logic       done_v  [4];
  logic [7:0] err_v   [4];
  logic       fev_v   [4];
  logic [3:0] fvec_v  [4];
  logic [1:0] st_v    [4];
  logic [7:0] err_a, err_b, err_d;
  logic [2:0] err_c;

  logic ab1, ab2, ob1, ob2, ad1, ad2, od1, od2;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] err;
    logic       fev;
    logic [3:0] fvec;
    logic [4:0] blen;
  } exp_t;
  exp_t exp_q[$];

  // 0: LAT=0 with selectable faults, 1: LAT=2 matched, 2: ERR_W=3, 3: LAT=0 against a 2-cycle unit
  reduce_stim_checker #(.WIDTH(4), .LAT(0), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stim(stim_v[0]),
    .dut_and(and_m[0]), .dut_or(or_m[0]), .busy(busy_v[0]), .done(done_v[0]),
    .err_cnt(err_a), .first_err_valid(fev_v[0]), .first_err_vec(fvec_v[0]),
    .state_dbg(st_v[0]));

  reduce_stim_checker #(.WIDTH(4), .LAT(2), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stim(stim_v[1]),
    .dut_and(and_m[1]), .dut_or(or_m[1]), .busy(busy_v[1]), .done(done_v[1]),
    .err_cnt(err_b), .first_err_valid(fev_v[1]), .first_err_vec(fvec_v[1]),
    .state_dbg(st_v[1]));

  reduce_stim_checker #(.WIDTH(4), .LAT(0), .ERR_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .stim(stim_v[2]),
    .dut_and(and_m[2]), .dut_or(or_m[2]), .busy(busy_v[2]), .done(done_v[2]),
    .err_cnt(err_c), .first_err_valid(fev_v[2]), .first_err_vec(fvec_v[2]),
    .state_dbg(st_v[2]));

  reduce_stim_checker #(.WIDTH(4), .LAT(0), .ERR_W(8)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .stim(stim_v[3]),
    .dut_and(and_m[3]), .dut_or(or_m[3]), .busy(busy_v[3]), .done(done_v[3]),
    .err_cnt(err_d), .first_err_valid(fev_v[3]), .first_err_vec(fvec_v[3]),
    .state_dbg(st_v[3]));

  assign err_v[0] = err_a;
  assign err_v[1] = err_b;
  assign err_v[2] = {5'd0, err_c};
  assign err_v[3] = err_d;

  // Reduction unit models
  assign and_m[0] = (mode == 2'd1 && stim_v[0] == 4'b1010) ? 1'b1 : &stim_v[0];
  assign or_m[0]  = (mode == 2'd2) ? 1'b0 : |stim_v[0];
  assign and_m[1] = ab2;
  assign or_m[1]  = ob2;
  assign and_m[2] = &stim_v[2];
  assign or_m[2]  = 1'b0;
  assign and_m[3] = ad2;
  assign or_m[3]  = od2;

  always @(posedge clk) begin
    ab1 <= &stim_v[1]; ab2 <= ab1;
    ob1 <= |stim_v[1]; ob2 <= ob1;
    ad1 <= &stim_v[3]; ad2 <= ad1;
    od1 <= |stim_v[3]; od2 <= od1;
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor / scoreboard
  int bcnt [4];
  int sbad [4];

  always @(negedge clk) begin
    exp_t e;
    int   es;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        bcnt[i] = 0;
        sbad[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (busy_v[i]) begin
          es = (bcnt[i] > 15) ? 15 : bcnt[i];
          if (int'(stim_v[i]) != es) sbad[i]++;
          bcnt[i]++;
        end
        if (done_v[i]) begin
          check("done_has_expectation", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("done_inst", i, int'(e.id));
            check("err_cnt", int'(err_v[i]), int'(e.err));
            check("first_err_valid", int'(fev_v[i]), int'(e.fev));
            check("first_err_vec", int'(fvec_v[i]), int'(e.fvec));
            check("busy_cycles", bcnt[i], int'(e.blen));
            check("stim_sequence_errors", sbad[i], 0);
            check("stim_after_done", int'(stim_v[i]), 0);
          end
          bcnt[i] = 0;
          sbad[i] = 0;
        end
      end
    end
  end

  // Driver
  task automatic sweep(input int id, input logic [1:0] m, input int pulse_vec,
                       input logic [7:0] x_err, input logic x_fev,
                       input logic [3:0] x_fvec, input int x_blen);
    exp_t e;
    int   n;
    e.id   = 2'(id);
    e.err  = x_err;
    e.fev  = x_fev;
    e.fvec = x_fvec;
    e.blen = 5'(x_blen);
    @(negedge clk);
    mode = m;
    exp_q.push_back(e);
    start[id] = 1'b1;
    @(posedge clk);
    #1;
    check("start_clears_err", int'(err_v[id]), 0);
    check("start_clears_fev", int'(fev_v[id]), 0);
    check("start_busy", int'(busy_v[id]), 1);
    @(negedge clk);
    start[id] = 1'b0;
    if (pulse_vec >= 0) begin
      n = 0;
      while (int'(stim_v[id]) != pulse_vec && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reach_pulse_vec", int'(stim_v[id]), pulse_vec);
      start[id] = 1'b1;
      @(negedge clk);
      start[id] = 1'b0;
    end
    n = 0;
    while (!done_v[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", int'(done_v[id]), 1);
    @(negedge clk);
    check("done_single_pulse", int'(done_v[id]), 0);
  endtask

  initial begin
    int n;
    start = 4'd0;
    mode  = 2'd0;
    rst_n = 1'b0;
    #1;
    check("rst_stim", int'(stim_v[0]), 0);
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    check("rst_err", int'(err_v[0]), 0);
    check("rst_fev", int'(fev_v[0]), 0);
    check("rst_state", int'(st_v[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean sweep with an ignored start at vector 5
    sweep(0, 2'd0, 5, 8'd0, 1'b0, 4'd0, 16);
    sweep(0, 2'd1, -1, 8'd1, 1'b1, 4'b1010, 16);
    sweep(0, 2'd2, -1, 8'd15, 1'b1, 4'b0001, 16);
    repeat (3) @(negedge clk);
    check("err_hold_after_done", int'(err_v[0]), 15);
    check("fvec_hold_after_done", int'(fvec_v[0]), 1);
    sweep(0, 2'd0, -1, 8'd0, 1'b0, 4'd0, 16);
    sweep(2, 2'd0, -1, 8'd7, 1'b1, 4'b0001, 16);
    sweep(1, 2'd0, -1, 8'd0, 1'b0, 4'd0, 18);
    sweep(3, 2'd0, -1, 8'd3, 1'b1, 4'b0001, 16);

    // async reset mid-sweep at vector 7 (fault mode gives nonzero state to clear)
    @(negedge clk);
    mode = 2'd2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (stim_v[0] != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec7", int'(stim_v[0]), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stim", int'(stim_v[0]), 0);
    check("midrst_busy", int'(busy_v[0]), 0);
    check("midrst_err", int'(err_v[0]), 0);
    check("midrst_fev", int'(fev_v[0]), 0);
    check("midrst_fvec", int'(fvec_v[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(st_v[0]), 0);
    check("post_rst_busy", int'(busy_v[0]), 0);
    sweep(0, 2'd0, -1, 8'd0, 1'b0, 4'd0, 16);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
